// File: rtl/mem_port_pkg.sv
// Shared definitions for the per-core memory request port: FSM state and
// access-type encodings plus default bus widths.
package mem_port_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_req_port.sv
// Per-core front end between a MIPS32 MEM stage and its shared-RAM arbiter
// port: holds a request until granted, stalls the core, captures load data.
module mem_req_port
  import mem_port_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_memread,
  input  logic              cpu_memwrite,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              arb_req,
  output logic [ADDR_W-1:0] arb_addr,
  output logic [DATA_W-1:0] arb_wdata,
  output logic              arb_memwrite,
  output logic              arb_memread,
  input  logic [DATA_W-1:0] arb_rdata,
  input  logic              arb_grant,
  output logic [CNT_W-1:0]  wait_cycles,
  output logic              err_rw
);

  state_t state, state_nxt;
  op_t    op;
  logic   access;

  assign access = cpu_memread | cpu_memwrite;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    arb_req      = 1'b0;
    arb_memread  = 1'b0;
    arb_memwrite = 1'b0;
    cpu_stall    = 1'b0;
    unique case (state)
      IDLE: begin
        cpu_stall = access;
        if (access) state_nxt = REQ;
      end
      REQ: begin
        arb_req      = 1'b1;
        arb_memread  = (op == OP_RD);
        arb_memwrite = (op == OP_WR);
        cpu_stall    = 1'b1;
        if (arb_grant) state_nxt = DONE;
      end
      // The grant seen here is stale (it answers last cycle's request),
      // so strobes stay low and it is ignored.
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst) cpu_stall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_addr  <= '0;
      arb_wdata <= '0;
      op        <= OP_RD;
      cpu_rdata <= '0;
      err_rw    <= 1'b0;
    end else begin
      if ((state == IDLE) && access) begin
        arb_addr  <= cpu_addr;
        arb_wdata <= cpu_wdata;
        op        <= cpu_memwrite ? OP_WR : OP_RD;
        if (cpu_memread && cpu_memwrite) err_rw <= 1'b1;
      end
      if ((state == REQ) && arb_grant && (op == OP_RD)) begin
        cpu_rdata <= arb_rdata;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   ((state == REQ) && !arb_grant),
    .count (wait_cycles)
  );

endmodule

// File: tb/tb_mem_req_port.sv
// Self-checking bench for mem_req_port: a delayed-grant arbiter and RAM
// surround the port; a transaction-level model predicts data and latency.
module tb_mem_req_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_memread, cpu_memwrite;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, arb_req, arb_memwrite, arb_memread, arb_grant;
  logic [31:0] arb_addr, arb_wdata, arb_rdata;
  logic [15:0] wait_cycles;
  logic        err_rw;

  logic        s_memread, s_grant, s_stall, s_req, s_mw, s_mr, s_err;
  logic [31:0] s_rdata, s_addr, s_wdata;
  logic [3:0]  s_wait;

  always #5 clk = ~clk;

  mem_req_port dut (
    .clk(clk), .rst(rst),
    .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .arb_req(arb_req), .arb_addr(arb_addr), .arb_wdata(arb_wdata),
    .arb_memwrite(arb_memwrite), .arb_memread(arb_memread),
    .arb_rdata(arb_rdata), .arb_grant(arb_grant),
    .wait_cycles(wait_cycles), .err_rw(err_rw)
  );

  mem_req_port #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .cpu_memread(s_memread), .cpu_memwrite(1'b0),
    .cpu_addr(32'h0000_0040), .cpu_wdata(32'h0),
    .cpu_rdata(s_rdata), .cpu_stall(s_stall),
    .arb_req(s_req), .arb_addr(s_addr), .arb_wdata(s_wdata),
    .arb_memwrite(s_mw), .arb_memread(s_mr),
    .arb_rdata(32'h1111_2222), .arb_grant(s_grant),
    .wait_cycles(s_wait), .err_rw(s_err)
  );

  // Environment: arbiter grants (registered) after `deny` extra request cycles.
  typedef struct { bit wr; logic [31:0] addr; } acc_t;
  logic [31:0] ram [256];
  logic [31:0] exp_mem [256];
  acc_t        log_q [$];
  int          deny = 0;
  int          deny_cnt;
  int          wr_events = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_grant <= 1'b0;
      deny_cnt  <= 0;
    end else if (arb_req) begin
      arb_grant <= (deny_cnt >= deny);
      deny_cnt  <= deny_cnt + 1;
    end else begin
      arb_grant <= 1'b0;
      deny_cnt  <= 0;
    end
  end

  always @(posedge clk) begin
    if (!rst && arb_grant && arb_memwrite) begin
      ram[arb_addr[9:2]] <= arb_wdata;
      wr_events = wr_events + 1;
      log_q.push_back('{1'b1, arb_addr});
    end else if (!rst && arb_grant && arb_memread) begin
      log_q.push_back('{1'b0, arb_addr});
    end
  end

  assign arb_rdata = (arb_grant && arb_memread) ? ram[arb_addr[9:2]] : 32'hBAD0_BAD0;

  // Transaction-level expectations.
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_rdata = 32'h0;
  int          exp_wait = 0;
  bit          exp_err = 1'b0;

  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int dny, input string name);
    int cyc;
    int wr0;
    bit seen_low;
    deny = dny;
    wr0 = wr_events;
    cpu_memread = rd;
    cpu_memwrite = wr;
    cpu_addr = addr;
    cpu_wdata = wdata;
    if (rd && wr) exp_err = 1'b1;
    if (wr) exp_mem[addr[9:2]] = wdata;
    else exp_rdata = exp_mem[addr[9:2]];
    exp_wait = (exp_wait + dny + 1 > 65535) ? 65535 : exp_wait + dny + 1;
    cyc = 0;
    seen_low = 1'b0;
    while (cyc < 40 && !seen_low) begin
      @(negedge clk);
      if (!cpu_stall) seen_low = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    total++;
    if (!seen_low || cyc != 3 + dny) begin
      bad++;
      $display("FAIL %s stall_len: got=%0d want=%0d (low seen=%0d)", name, cyc, 3 + dny, seen_low);
    end
    total++;
    if (arb_req !== 1'b0 || arb_memwrite !== 1'b0 || arb_memread !== 1'b0) begin
      bad++;
      $display("FAIL %s done_strobes: req=%b mw=%b mr=%b want 0", name, arb_req, arb_memwrite, arb_memread);
    end
    total++;
    if (cpu_rdata !== exp_rdata) begin
      bad++;
      $display("FAIL %s rdata: got=%h want=%h", name, cpu_rdata, exp_rdata);
    end
    total++;
    if (wait_cycles !== 16'(exp_wait)) begin
      bad++;
      $display("FAIL %s wait_cycles: got=%0d want=%0d", name, wait_cycles, exp_wait);
    end
    total++;
    if (err_rw !== exp_err) begin
      bad++;
      $display("FAIL %s err_rw: got=%b want=%b", name, err_rw, exp_err);
    end
    @(posedge clk); #1;
    cpu_memread = 1'b0;
    cpu_memwrite = 1'b0;
    total++;
    if (wr_events - wr0 != (wr ? 1 : 0)) begin
      bad++;
      $display("FAIL %s write_count: got=%0d want=%0d", name, wr_events - wr0, wr ? 1 : 0);
    end
    total++;
    if (ram[addr[9:2]] !== exp_mem[addr[9:2]]) begin
      bad++;
      $display("FAIL %s ram: got=%h want=%h", name, ram[addr[9:2]], exp_mem[addr[9:2]]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_memread = 1'b1;
    cpu_memwrite = 1'b0;
    cpu_addr = 32'h0;
    cpu_wdata = 32'h0;
    s_memread = 1'b0;
    s_grant = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({cpu_stall, arb_req, arb_memwrite, arb_memread, err_rw} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got=%b want=00000", {cpu_stall, arb_req, arb_memwrite, arb_memread, err_rw});
    end
    total++;
    if (arb_addr !== 32'h0 || arb_wdata !== 32'h0 || cpu_rdata !== 32'h0 || wait_cycles !== 16'h0) begin
      bad++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h wait=%0d want all 0", arb_addr, arb_wdata, cpu_rdata, wait_cycles);
    end
    cpu_memread = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    ram[8'h04] = 32'hDEAD_BEEF;
    exp_mem[8'h04] = 32'hDEAD_BEEF;
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 0, "load");
  endtask

  task automatic test_store();
    do_access(1'b0, 1'b1, 32'h20, 32'h1234_5678, 0, "store");
  endtask

  task automatic test_contention();
    do_access(1'b1, 1'b0, 32'h20, 32'h0, 4, "contend_rd");
    do_access(1'b0, 1'b1, 32'h24, 32'hCAFE_F00D, 2, "contend_wr");
  endtask

  task automatic test_back_to_back();
    log_q.delete();
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 0, "b2b_load");
    do_access(1'b0, 1'b1, 32'h14, 32'hA5A5_5A5A, 0, "b2b_store");
    total++;
    if (log_q.size() != 2) begin
      bad++;
      $display("FAIL b2b_order: got %0d ram ops want 2", log_q.size());
    end else if (log_q[0].wr != 1'b0 || log_q[0].addr !== 32'h10 ||
                 log_q[1].wr != 1'b1 || log_q[1].addr !== 32'h14) begin
      bad++;
      $display("FAIL b2b_order: got %0d@%h,%0d@%h want 0@10,1@14",
               log_q[0].wr, log_q[0].addr, log_q[1].wr, log_q[1].addr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      bit          wr;
      logic [31:0] a;
      wr = 1'($urandom_range(0, 1));
      a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      do_access(!wr, wr, a, $urandom, $urandom_range(0, 4), "random");
    end
  endtask

  task automatic test_err();
    do_access(1'b1, 1'b1, 32'h40, 32'h0BAD_C0DE, 1, "rw_both");
  endtask

  task automatic test_reset_mid_req();
    int          wr0;
    logic [31:0] old;
    wr0 = wr_events;
    old = ram[8'h0C];
    deny = 6;
    cpu_memwrite = 1'b1;
    cpu_addr = 32'h30;
    cpu_wdata = 32'h7777_7777;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (arb_req !== 1'b0 || cpu_stall !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_ctrl: req=%b stall=%b want 0 0", arb_req, cpu_stall);
    end
    total++;
    if (wait_cycles !== 16'h0 || err_rw !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_regs: wait=%0d err=%b want 0 0", wait_cycles, err_rw);
    end
    cpu_memwrite = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_wait = 0;
    exp_err = 1'b0;
    exp_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ram[8'h0C] !== old || wr_events != wr0) begin
      bad++;
      $display("FAIL mid_reset_ram: got=%h writes=%0d want=%h writes=0", ram[8'h0C], wr_events - wr0, old);
    end
    do_access(1'b1, 1'b0, 32'h30, 32'h0, 0, "after_reset");
  endtask

  task automatic test_saturation();
    s_memread = 1'b1;
    s_grant = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (s_wait !== 4'd15 || s_stall !== 1'b1) begin
      bad++;
      $display("FAIL sat_hold: wait=%0d stall=%b want 15 1", s_wait, s_stall);
    end
    s_grant = 1'b1;
    @(posedge clk); #1;
    s_grant = 1'b0;
    @(negedge clk);
    total++;
    if (s_wait !== 4'd15 || s_stall !== 1'b0 || s_rdata !== 32'h1111_2222) begin
      bad++;
      $display("FAIL sat_done: wait=%0d stall=%b rdata=%h want 15 0 11112222", s_wait, s_stall, s_rdata);
    end
    @(posedge clk); #1;
    s_memread = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = $urandom;
      ram[i] = v;
      exp_mem[i] = v;
    end
    test_reset();
    test_load();
    test_store();
    test_contention();
    test_back_to_back();
    test_random();
    test_err();
    test_reset_mid_req();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_req_port.md
Name: mem_req_port

Overview:
- Per-core memory request front end; one instance sits between each MIPS32 core's MEM stage and its port on the shared-RAM arbiter.
- Turns the core's single-cycle memread/memwrite into a held request/grant handshake.
- Stalls the core until the access completes, captures read data, and counts cycles lost to contention.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
CNT_W, 16, width of the saturating wait-cycle counter

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
cpu_memread  in  1  MEM-stage load request
cpu_memwrite  in  1  MEM-stage store request
cpu_addr  in  ADDR_W  MEM-stage address
cpu_wdata  in  DATA_W  MEM-stage store data
cpu_rdata  out  DATA_W  load result to the core
cpu_stall  out  1  freezes the core pipeline while high
arb_req  out  1  request to arbiter
arb_addr  out  ADDR_W  address to arbiter
arb_wdata  out  DATA_W  write data to arbiter
arb_memwrite  out  1  write strobe to arbiter
arb_memread  out  1  read strobe to arbiter
arb_rdata  in  DATA_W  read data from arbiter; valid in a granted cycle
arb_grant  in  1  registered grant from arbiter
wait_cycles  out  CNT_W  saturating count of REQ cycles without grant
err_rw  out  1  sticky flag: memread and memwrite seen together

Behaviour:
- States:
  - IDLE (0): no access in flight.
  - REQ (1): request held toward the arbiter.
  - DONE (2): one-cycle completion/release state.
- Reset (async, rst high):
  - state = IDLE.
  - arb_req, arb_memwrite, arb_memread, err_rw = 0.
  - arb_addr, arb_wdata, cpu_rdata, wait_cycles = 0.
  - cpu_stall forced 0 while rst is high.
- IDLE:
  - cpu_stall = cpu_memread | cpu_memwrite (combinational, same cycle).
  - If an access is present, at the clock edge:
    - latch addr/wdata/op;
    - op = write if cpu_memwrite, else read;
    - go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - arb_req = 1; arb_addr/arb_wdata/strobes driven from the latched registers, not from cpu_*.
  - cpu_stall = 1.
  - arb_grant sampled high at an edge means the access was performed this cycle:
    - read: arb_rdata is captured into cpu_rdata;
    - write: RAM commits at this edge.
  - Transition to DONE at that edge.
  - Each REQ cycle with arb_grant = 0 increments wait_cycles, saturating at 2^CNT_W-1.
- DONE (exactly one cycle):
  - arb_req = 0, arb_memread = 0, arb_memwrite = 0.
  - cpu_stall = 0, so the core advances at the end of this cycle.
  - Go to IDLE unconditionally.
  - The arbiter's grant is still high in this cycle because it sampled req = 1 at the previous edge. That stale grant is ignored, and the zeroed strobes prevent a second RAM write.
- arb_grant is ignored in IDLE and DONE.
- Minimum latency, no contention:
  - cycle 0: IDLE, stall = 1
  - cycle 1: REQ, grant = 0
  - cycle 2: REQ, grant = 1
  - cycle 3: DONE, stall = 0
  - The core loses 3 cycles per access.
- cpu_rdata holds the last captured load value until the next read completes; writes leave it unchanged.
- Simultaneous memread & memwrite: treated as a write; err_rw sets and stays set until reset.
- Back-to-back accesses:
  - The next instruction's access appears in the IDLE cycle after DONE.
  - No request is issued from DONE, so the arbiter has dropped the grant before the new REQ cycle.
- Reset mid-REQ: the request is abandoned immediately (arb_req low asynchronously); no RAM write can occur afterwards.

Decomposition:
- Shared package (mem_port_pkg):
  - state encodings IDLE/REQ/DONE (2-bit);
  - default ADDR_W/DATA_W;
  - op encoding (OP_RD = 0, OP_WR = 1).
- One sub-module: sat_counter (parameterised width, inc enable, async reset), used for wait_cycles.

Test Plan:
- Uncontended load:
  - stimulus: cpu_memread = 1, addr = 0x10; RAM[0x10] = 0xDEADBEEF; arbiter grants one cycle after req.
  - required: stall high in cycles 0-2, low in cycle 3; cpu_rdata = 0xDEADBEEF in cycle 3; wait_cycles = 1.
- Uncontended store:
  - stimulus: cpu_memwrite = 1, addr = 0x20, wdata = 0x12345678.
  - required: exactly one cycle with arb_memwrite & arb_grant; RAM[0x20] = 0x12345678; no write in DONE despite the stale grant.
- Contention:
  - stimulus: second port requesting continuously; arbiter toggles.
  - required: grant delayed; wait_cycles increments each ungranted REQ cycle; stall held throughout; correct data on completion.
- Back-to-back:
  - stimulus: load 0x10, then store 0x14 on the next instruction.
  - required: second access enters REQ only after IDLE; RAM sees exactly one read then one write, in that order.
- Reset mid-REQ:
  - stimulus: assert rst while in REQ.
  - required: arb_req = 0 and cpu_stall = 0 immediately; RAM unchanged; wait_cycles = 0.
- Error and saturation:
  - stimulus: memread & memwrite both high; separately, CNT_W = 4 with grant withheld 20 cycles.
  - required: first case writes and sets err_rw = 1; second case holds wait_cycles = 15.
